// File: rtl/alu_result_serializer.sv
// alu_result_serializer: captures one ALU result by valid/ready handshake and shifts it out
// MSB-first as a {marker, zero, carry, result} frame, counting completed frames.
module alu_result_serializer #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_carry,
   input  logic              in_zero,
   output logic              ser_out,
   output logic              ser_frame,
   output logic              done,
   output logic [7:0]        frame_cnt
);
   localparam int W  = DATA_W + 3;
   localparam int BW = $clog2(W);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t        state, state_nxt;
   logic [W-1:0]  sreg, sreg_nxt;
   logic [BW-1:0] bit_cnt, bit_nxt;
   logic [7:0]    div, div_nxt;
   logic          bit_end;
   always_comb begin
      state_nxt = state;
      sreg_nxt  = sreg;
      bit_nxt   = bit_cnt;
      div_nxt   = div;
      bit_end   = div == 8'(CLK_DIV - 1);
      if (state == IDLE && in_valid && in_ready) begin
         state_nxt = SHIFT;
         sreg_nxt  = {1'b1, in_zero, in_carry, in_result};
         bit_nxt   = '0;
         div_nxt   = '0;
      end else if (state == SHIFT) begin
         div_nxt = bit_end ? 8'd0 : div + 8'd1;
         if (bit_end && bit_cnt == BW'(W - 1))
            state_nxt = DONE;
         else if (bit_end) begin
            bit_nxt  = bit_cnt + BW'(1);
            sreg_nxt = sreg << 1;
         end
      end else if (state == DONE)
         state_nxt = IDLE;
   end
   // outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sreg      <= '0;
         bit_cnt   <= '0;
         div       <= '0;
         in_ready  <= 1'b1;
         ser_out   <= 1'b0;
         ser_frame <= 1'b0;
         done      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state     <= state_nxt;
         sreg      <= sreg_nxt;
         bit_cnt   <= bit_nxt;
         div       <= div_nxt;
         in_ready  <= state_nxt == IDLE;
         ser_frame <= state_nxt == SHIFT;
         ser_out   <= state_nxt == SHIFT && sreg_nxt[W-1];
         done      <= state_nxt == DONE;
         frame_cnt <= frame_cnt + 8'(state == DONE);
      end
   end
endmodule

// File: tb/tb_alu_result_serializer.sv
// tb_alu_result_serializer: table-driven and randomized checks of the serial frame,
// timing, input blocking, mid-frame reset and frame counter wrap.
module tb_alu_result_serializer;
   localparam int D = 2;
   localparam int W = 11;
   logic       clk = 0, rst = 1, in_valid = 0, in_carry = 0, in_zero = 0;
   logic [7:0] in_result = '0;
   logic       in_ready, ser_out, ser_frame, done;
   logic [7:0] frame_cnt;
   int         checks = 0, errors = 0, model_cnt = 0;
   time        last_acc = 0;
   bit         prev_hold = 0;
   typedef struct {
      logic [7:0]   r;
      logic         c;
      logic         z;
      logic [W-1:0] f;
   } vec_t;
   vec_t tbl [5];

   alu_result_serializer #(.DATA_W(8), .CLK_DIV(D)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_carry(in_carry), .in_zero(in_zero),
      .ser_out(ser_out), .ser_frame(ser_frame), .done(done), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [W-1:0] model_frame(input logic [7:0] r, input logic c, input logic z);
      return {1'b1, z, c, r};
   endfunction

   // mode 0: plain, 1: in_valid pulsed with other data mid-frame, 2: in_valid held high
   task automatic run_frame(input logic [7:0] r, input logic c, input logic z,
                            input logic [W-1:0] exp, input int mode);
      logic [W-1:0] got = '0;
      int t = 0, nf = 0, bad = 0, dn_at = 0, dn_n = 0, rdy_n = 0;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("ready_wait", 32'(t < 100), 1);
      in_result = r;
      in_carry  = c;
      in_zero   = z;
      in_valid  = 1;
      @(posedge clk);
      if (mode == 2 && prev_hold) check("spacing", 32'(($time - last_acc) / 10), W * D + 2);
      last_acc  = $time;
      prev_hold = mode == 2;
      #1 in_valid = mode == 2;
      for (int k = 1; k <= W * D + 2; k++) begin
         @(negedge clk);
         if (k <= W * D) begin
            if (ser_frame) nf++;
            if (ser_out !== exp[W-1-(k-1)/D]) bad++;
            if ((k - 1) % D == 0) got = {got[W-2:0], ser_out};
         end else if (ser_frame || ser_out) bad++;
         if (done) begin
            dn_n++;
            dn_at = k;
         end
         if (in_ready && k <= W * D + 1) rdy_n++;
         if (mode == 1 && k == 3) begin
            in_valid  = 1;
            in_result = 8'hFF;
            in_carry  = ~c;
            in_zero   = ~z;
         end
         if (mode == 1 && k == 7) in_valid = 0;
      end
      model_cnt = (model_cnt + 1) % 256;
      check("frame_bits", 32'(got), 32'(exp));
      check("bit_hold", bad, 0);
      check("frame_len", nf, W * D);
      check("done_count", dn_n, 1);
      check("done_cycle", dn_at, W * D + 1);
      check("ready_busy", rdy_n, 0);
      check("ready_after", 32'(in_ready), 1);
      check("frame_cnt", 32'(frame_cnt), 32'(model_cnt));
   endtask

   initial begin
      int dn_n;
      logic [7:0] r;
      logic c, z;
      tbl[0] = '{8'hA5, 1'b1, 1'b0, 11'b101_1010_0101};
      tbl[1] = '{8'h00, 1'b1, 1'b0, 11'b101_0000_0000};
      tbl[2] = '{8'hFF, 1'b1, 1'b1, 11'b111_1111_1111};
      tbl[3] = '{8'h3C, 1'b0, 1'b0, 11'b100_0011_1100};
      tbl[4] = '{8'h81, 1'b0, 1'b1, 11'b110_1000_0001};
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check("rst_ready", 32'(in_ready), 1);
      check("rst_ser_out", 32'(ser_out), 0);
      check("rst_frame", 32'(ser_frame), 0);
      check("rst_done", 32'(done), 0);
      check("rst_cnt", 32'(frame_cnt), 0);
      for (int i = 0; i < 5; i++) run_frame(tbl[i].r, tbl[i].c, tbl[i].z, tbl[i].f, 0);
      run_frame(8'h5A, 1'b0, 1'b1, 11'b110_0101_1010, 1);
      for (int i = 0; i < 3; i++) run_frame(8'h00, 1'b0, 1'b1, 11'b110_0000_0000, 2);
      in_valid = 0;
      for (int i = 0; i < 10; i++) begin
         r = 8'($urandom);
         c = 1'($urandom);
         z = 1'($urandom);
         run_frame(r, c, z, model_frame(r, c, z), 0);
      end
      @(negedge clk);
      in_result = 8'h77;
      in_valid  = 1;
      @(posedge clk);
      #1 in_valid = 0;
      repeat (7) @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      model_cnt = 0;
      @(negedge clk);
      check("mid_rst_ready", 32'(in_ready), 1);
      check("mid_rst_ser_out", 32'(ser_out), 0);
      check("mid_rst_frame", 32'(ser_frame), 0);
      check("mid_rst_cnt", 32'(frame_cnt), 0);
      dn_n = 0;
      for (int k = 0; k < 30; k++) begin
         if (done || ser_frame) dn_n++;
         @(negedge clk);
      end
      check("mid_rst_no_done", dn_n, 0);
      for (int i = 0; i < 256; i++) begin
         r = 8'($urandom);
         c = 1'($urandom);
         z = 1'($urandom);
         run_frame(r, c, z, model_frame(r, c, z), 0);
      end
      check("cnt_wrap", 32'(frame_cnt), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
